// File: rtl/baccarat_pkg.sv
// baccarat_pkg: shared types and constants for the Baccarat round sequencer.
//   state_t         - deal_fsm state encoding (CLEAR exists only when
//                     DEAL_FSM_AUTO_RESTART_EN is defined)
//   FACE_THRESHOLD  - card codes above this count as zero (10, J, Q, K)
//   NATURAL_THRESHOLD - a two-card total at or above this ends the round
//   PLAYER_DRAW_MAX - player (and standing-player banker) draws at or below
//   card_value()    - maps a 4-bit card code to its 0-9 point value
`timescale 1ns/1ps

package baccarat_pkg;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CARD_W  = 4;

    localparam logic [SCORE_W-1:0] FACE_THRESHOLD    = SCORE_W'(9);
    localparam logic [SCORE_W-1:0] NATURAL_THRESHOLD = SCORE_W'(8);
    localparam logic [SCORE_W-1:0] PLAYER_DRAW_MAX   = SCORE_W'(5);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_DEAL_P1     = 4'd1,
        S_DEAL_D1     = 4'd2,
        S_DEAL_P2     = 4'd3,
        S_DEAL_D2     = 4'd4,
        S_EVAL        = 4'd5,
        S_DEAL_P3     = 4'd6,
        S_BANKER_EVAL = 4'd7,
        S_DEAL_D3     = 4'd8,
        S_RESULT      = 4'd9,
        S_DONE        = 4'd10
`ifdef DEAL_FSM_AUTO_RESTART_EN
        ,
        S_CLEAR       = 4'd11
`endif
    } state_t;

    // Point value of a card code: tens and face cards (and "no card") are zero.
    function automatic logic [SCORE_W-1:0] card_value(input logic [CARD_W-1:0] code);
        logic [SCORE_W-1:0] v;
        v = SCORE_W'(code);
        if (code > CARD_W'(FACE_THRESHOLD)) begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// banker_draw_rule: combinational banker third-card table, applied after the
// player has taken a third card.
//   dscore - banker two-card total, 0-9
//   v      - point value of the player's third card, 0-9
//   draw   - banker takes a third card
`timescale 1ns/1ps

module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] v,
    output logic               draw
);

    // Window tests on v keep each row of the table on one line.
    logic v_is_8;
    logic v_2_to_7;
    logic v_4_to_7;
    logic v_6_to_7;

    always_comb begin
        v_is_8   = (v == SCORE_W'(8));
        v_2_to_7 = (v >= SCORE_W'(2)) && (v <= SCORE_W'(7));
        v_4_to_7 = (v >= SCORE_W'(4)) && (v <= SCORE_W'(7));
        v_6_to_7 = (v >= SCORE_W'(6)) && (v <= SCORE_W'(7));
    end

    // Banker table; 7 and above always stand.
    always_comb begin
        draw = 1'b0;
        case (dscore)
            SCORE_W'(0),
            SCORE_W'(1),
            SCORE_W'(2): draw = 1'b1;
            SCORE_W'(3): draw = !v_is_8;
            SCORE_W'(4): draw = v_2_to_7;
            SCORE_W'(5): draw = v_4_to_7;
            SCORE_W'(6): draw = v_6_to_7;
            default:     draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_fsm.sv
// deal_fsm: Baccarat round sequencer. Deals four opening cards, applies the
// natural / player third-card / banker third-card rules, then latches the
// win lights.
//   slow_clock          - clock, rising edge
//   resetb              - asynchronous active-low reset
//   pscore, dscore      - player / dealer hand totals (0-9) from the scorer
//   pcard3              - raw player third-card code (0 = none)
//   load_pcard1..3      - player card-register load strobes (one cycle each)
//   load_dcard1..3      - dealer card-register load strobes (one cycle each)
//   player_win_light    - player won or tie (held until reset / restart)
//   dealer_win_light    - dealer won or tie (held until reset / restart)
//   clear_hands         - clear all card registers
// Optional feature: DEAL_FSM_AUTO_RESTART_EN - DONE lasts one cycle, then a
// CLEAR cycle pulses clear_hands, drops the lights and a new round starts.
// Without it DONE is absorbing and clear_hands is tied low.
`timescale 1ns/1ps

module deal_fsm
    import baccarat_pkg::*;
(
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic [SCORE_W-1:0] pscore,
    input  logic [SCORE_W-1:0] dscore,
    input  logic [CARD_W-1:0]  pcard3,
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               player_win_light,
    output logic               dealer_win_light,
    output logic               clear_hands
);

    state_t             state;
    state_t             next_state;
    logic [SCORE_W-1:0] third_value;
    logic               banker_draw;
    logic               is_natural;
    logic               player_draws;
    logic               stood_banker_draws;

    assign third_value = card_value(pcard3);

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .v      (third_value),
        .draw   (banker_draw)
    );

    // EVAL decision terms, in priority order.
    always_comb begin
        is_natural         = (pscore >= NATURAL_THRESHOLD) || (dscore >= NATURAL_THRESHOLD);
        player_draws       = (pscore <= PLAYER_DRAW_MAX);
        stood_banker_draws = (dscore <= PLAYER_DRAW_MAX);
    end

    // Next-state selection.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    next_state = S_DEAL_P1;
            S_DEAL_P1: next_state = S_DEAL_D1;
            S_DEAL_D1: next_state = S_DEAL_P2;
            S_DEAL_P2: next_state = S_DEAL_D2;
            S_DEAL_D2: next_state = S_EVAL;
            S_EVAL: begin
                if (is_natural) begin
                    next_state = S_RESULT;
                end else if (player_draws) begin
                    next_state = S_DEAL_P3;
                end else if (stood_banker_draws) begin
                    next_state = S_DEAL_D3;
                end else begin
                    next_state = S_RESULT;
                end
            end
            S_DEAL_P3:     next_state = S_BANKER_EVAL;
            S_BANKER_EVAL: next_state = banker_draw ? S_DEAL_D3 : S_RESULT;
            S_DEAL_D3:     next_state = S_RESULT;
            S_RESULT:      next_state = S_DONE;
`ifdef DEAL_FSM_AUTO_RESTART_EN
            S_DONE:        next_state = S_CLEAR;
            S_CLEAR:       next_state = S_DEAL_P1;
`else
            S_DONE:        next_state = S_DONE;
`endif
            default:       next_state = S_IDLE;
        endcase
    end

    // State and output registers. Strobes are decoded from next_state so each
    // one is high exactly while the FSM sits in its DEAL_* state, and reset
    // clears them asynchronously together with the state.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state            <= S_IDLE;
            load_pcard1      <= 1'b0;
            load_pcard2      <= 1'b0;
            load_pcard3      <= 1'b0;
            load_dcard1      <= 1'b0;
            load_dcard2      <= 1'b0;
            load_dcard3      <= 1'b0;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
`ifdef DEAL_FSM_AUTO_RESTART_EN
            clear_hands      <= 1'b0;
`endif
        end else begin
            state       <= next_state;
            load_pcard1 <= (next_state == S_DEAL_P1);
            load_dcard1 <= (next_state == S_DEAL_D1);
            load_pcard2 <= (next_state == S_DEAL_P2);
            load_dcard2 <= (next_state == S_DEAL_D2);
            load_pcard3 <= (next_state == S_DEAL_P3);
            load_dcard3 <= (next_state == S_DEAL_D3);
            // Final scores are settled while in RESULT; a tie lights both.
            if (state == S_RESULT) begin
                player_win_light <= (pscore >= dscore);
                dealer_win_light <= (dscore >= pscore);
            end
`ifdef DEAL_FSM_AUTO_RESTART_EN
            else if (next_state == S_CLEAR) begin
                player_win_light <= 1'b0;
                dealer_win_light <= 1'b0;
            end
            clear_hands <= (next_state == S_CLEAR);
`endif
        end
    end

`ifndef DEAL_FSM_AUTO_RESTART_EN
    assign clear_hands = 1'b0;
`endif

endmodule

// File: tb/tb_deal_fsm.sv
// tb_deal_fsm: self-checking bench for deal_fsm. A small card-register
// datapath feeds the scores back; an outcome model computes the expected
// strobe schedule and lights from the dealt cards using the game rules.
`timescale 1ns/1ps

module tb_deal_fsm;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, clear_hands;

    int checks   = 0;
    int failures = 0;

    // Cards to deal this round: P1, D1, P2, D2, P3, D3.
    logic [3:0] deck [6];
    logic [3:0] held [6];

    localparam logic [5:0] ST_P1 = 6'b100000;
    localparam logic [5:0] ST_D1 = 6'b010000;
    localparam logic [5:0] ST_P2 = 6'b001000;
    localparam logic [5:0] ST_D2 = 6'b000100;
    localparam logic [5:0] ST_P3 = 6'b000010;
    localparam logic [5:0] ST_D3 = 6'b000001;
    localparam logic [5:0] ST_NONE = 6'b000000;

    logic [5:0] strobes;
    logic [1:0] lights;
    assign strobes = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
    assign lights  = {player_win_light, dealer_win_light};

    deal_fsm dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .clear_hands      (clear_hands)
    );

    always #5 slow_clock = ~slow_clock;

    function automatic int pts(input logic [3:0] code);
        return (code >= 4'd10) ? 0 : int'(code);
    endfunction

    function automatic logic [3:0] hand(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return 4'((pts(a) + pts(b) + pts(c)) % 10);
    endfunction

    // Card-register datapath: captures a card on the edge that leaves its DEAL state.
    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 6; i++) held[i] <= 4'd0;
        end else if (clear_hands) begin
            for (int i = 0; i < 6; i++) held[i] <= 4'd0;
        end else begin
            if (load_pcard1) held[0] <= deck[0];
            if (load_dcard1) held[1] <= deck[1];
            if (load_pcard2) held[2] <= deck[2];
            if (load_dcard2) held[3] <= deck[3];
            if (load_pcard3) held[4] <= deck[4];
            if (load_dcard3) held[5] <= deck[5];
        end
    end

    assign pscore = hand(held[0], held[2], held[4]);
    assign dscore = hand(held[1], held[3], held[5]);
    assign pcard3 = held[4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Banker table as per-total bitmasks over the player's third-card value.
    function automatic bit banker_takes(input int d, input int v);
        logic [15:0] mask;
        case (d)
            0, 1, 2: mask = 16'hFFFF;
            3:       mask = 16'hFEFF;
            4:       mask = 16'h00FC;
            5:       mask = 16'h00F0;
            6:       mask = 16'h00C0;
            default: mask = 16'h0000;
        endcase
        return mask[v];
    endfunction

    task automatic apply_reset();
        @(negedge slow_clock);
        resetb = 1'b0;
        #1;
        check_val("reset_strobes", 32'(strobes), 32'(ST_NONE));
        check_val("reset_lights", 32'(lights), 32'd0);
        check_val("reset_clear", 32'(clear_hands), 32'd0);
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    // One full round from reset using the cards in deck[].
    task automatic run_round(input string name);
        logic [5:0] sched [$];
        int  p, d, fp, fd, done_edge, last_edge;
        bit  pdraw, ddraw;
        logic [1:0] exp_l, want_l;
        logic [5:0] want_s;

        p = (pts(deck[0]) + pts(deck[2])) % 10;
        d = (pts(deck[1]) + pts(deck[3])) % 10;
        pdraw = 1'b0;
        ddraw = 1'b0;
        if (p < 8 && d < 8) begin
            if (p <= 5) begin
                pdraw = 1'b1;
                ddraw = banker_takes(d, pts(deck[4]));
            end else begin
                ddraw = (d <= 5);
            end
        end
        fp = (p + (pdraw ? pts(deck[4]) : 0)) % 10;
        fd = (d + (ddraw ? pts(deck[5]) : 0)) % 10;
        exp_l = {1'(fp >= fd), 1'(fd >= fp)};

        sched = {ST_P1, ST_D1, ST_P2, ST_D2, ST_NONE};
        if (pdraw) sched.push_back(ST_P3);
        if (pdraw) sched.push_back(ST_NONE);
        if (ddraw) sched.push_back(ST_D3);
        sched.push_back(ST_NONE);
        done_edge = sched.size() + 1;
`ifdef DEAL_FSM_AUTO_RESTART_EN
        last_edge = done_edge;
`else
        last_edge = done_edge + 2;
`endif

        apply_reset();
        for (int e = 1; e <= last_edge; e++) begin
            @(posedge slow_clock);
            #1;
            want_s = (e <= sched.size()) ? sched[e-1] : ST_NONE;
            want_l = (e >= done_edge) ? exp_l : 2'b00;
            check_val({name, "_strobes"}, 32'(strobes), 32'(want_s));
            check_val({name, "_lights"}, 32'(lights), 32'(want_l));
            check_val({name, "_clear"}, 32'(clear_hands), 32'd0);
        end
`ifdef DEAL_FSM_AUTO_RESTART_EN
        @(posedge slow_clock);
        #1;
        check_val({name, "_clear_pulse"}, 32'(clear_hands), 32'd1);
        check_val({name, "_clear_lights"}, 32'(lights), 32'd0);
        @(posedge slow_clock);
        #1;
        check_val({name, "_restart_p1"}, 32'(strobes), 32'(ST_P1));
        check_val({name, "_restart_clear"}, 32'(clear_hands), 32'd0);
`endif
    endtask

    task automatic set_deck(input logic [3:0] p1, input logic [3:0] d1, input logic [3:0] p2,
                            input logic [3:0] d2, input logic [3:0] p3, input logic [3:0] d3);
        deck[0] = p1; deck[1] = d1; deck[2] = p2;
        deck[3] = d2; deck[4] = p3; deck[5] = d3;
    endtask

    initial begin
        set_deck(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        check_val("por_strobes", 32'(strobes), 32'(ST_NONE));
        check_val("por_lights", 32'(lights), 32'd0);

        // Natural 8 vs 3: player only.
        set_deck(4'd3, 4'd1, 4'd5, 4'd2, 4'd9, 4'd9);
        run_round("natural");
        // Player 4 draws an 8 (final 2), banker 3 holds on 8: dealer only.
        set_deck(4'd2, 4'd1, 4'd2, 4'd2, 4'd8, 4'd4);
        run_round("banker_holds");
        // Player stands on 7 against 6.
        set_deck(4'd3, 4'd2, 4'd4, 4'd4, 4'd1, 4'd1);
        run_round("player_stands");
        // Face third card counts zero, banker 3 draws a 2: 5/5 tie.
        set_deck(4'd2, 4'd1, 4'd3, 4'd2, 4'd12, 4'd2);
        run_round("face_tie");
        // Player stands on 6, banker 5 draws.
        set_deck(4'd1, 4'd2, 4'd5, 4'd3, 4'd7, 4'd3);
        run_round("stood_banker_draws");

        // Reset while sitting in DEAL_P3, between edges.
        set_deck(4'd2, 4'd1, 4'd3, 4'd2, 4'd12, 4'd2);
        apply_reset();
        for (int e = 1; e <= 6; e++) @(posedge slow_clock);
        #1;
        check_val("midp3_strobe", 32'(strobes), 32'(ST_P3));
        @(negedge slow_clock);
        resetb = 1'b0;
        #1;
        check_val("async_strobes", 32'(strobes), 32'(ST_NONE));
        check_val("async_lights", 32'(lights), 32'd0);
        @(negedge slow_clock);
        resetb = 1'b1;
        @(posedge slow_clock);
        #1;
        check_val("rerelease_p1", 32'(strobes), 32'(ST_P1));

        // Random rounds.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 6; i++) deck[i] = 4'($urandom_range(1, 13));
            run_round($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
